// File: rtl/unsigned_16by8_div_seq.sv
// Iterative unsigned 16-by-8 restoring divider with valid/ready handshakes.
// TRUNC low quotient bits are skipped to shorten latency; TRUNC = 0 is exact.
module unsigned_16by8_div_seq #(
    parameter int TRUNC = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] z,
    input  logic [7:0]  y,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] q,
    output logic [15:0] r,
    output logic        dbz
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [15:0] LOW_MASK = 16'((32'd1 << TRUNC) - 32'd1);
    localparam logic [3:0]  LAST_IDX = 4'(TRUNC);

    state_t      state;
    state_t      state_next;
    logic [15:0] z_reg;
    logic [7:0]  y_reg;
    logic [7:0]  p;
    logic [3:0]  idx;
    logic [9:0]  step;

    // One restoring step: {quotient bit, new partial remainder}. The stored
    // remainder is always below y, so only the shifted value P' needs bit 8.
    function automatic logic [9:0] restore_step(input logic [7:0] p_in,
                                                input logic       z_bit,
                                                input logic [7:0] d);
        logic [8:0] shifted;
        shifted = {p_in, z_bit};
        if (shifted >= {1'b0, d})
            return {1'b1, shifted - {1'b0, d}};
        else
            return {1'b0, shifted};
    endfunction

    assign step = restore_step(p, z_reg[idx], y_reg);

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid)
                    state_next = (y == 8'd0) ? DONE : RUN;
            end
            RUN: begin
                if (idx == LAST_IDX)
                    state_next = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            z_reg <= '0;
            y_reg <= '0;
            p     <= '0;
            idx   <= '0;
            q     <= '0;
            r     <= '0;
            dbz   <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        z_reg <= z;
                        y_reg <= y;
                        p     <= '0;
                        idx   <= 4'd15;
                        if (y == 8'd0) begin
                            q   <= 16'hFFFF;
                            r   <= z;
                            dbz <= 1'b1;
                        end else begin
                            q   <= '0;
                            dbz <= 1'b0;
                        end
                    end
                end
                RUN: begin
                    p      <= step[7:0];
                    q[idx] <= step[9];
                    idx    <= idx - 4'd1;
                    // Skipped low dividend bits pass straight into the remainder.
                    if (idx == LAST_IDX)
                        r <= ({7'd0, step[8:0]} << TRUNC) | (z_reg & LOW_MASK);
                end
                default: ;
            endcase
        end
    end

endmodule
